// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with optional skid entry and saturating stall/bubble counters
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of all held entries; offered input is dropped
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data sampled on accept
//   out_valid/out_ready   downstream handshake; out_ctrl is 0 whenever out_valid is 0
//   out_data              head payload, retains its last value on a bubble
//   stall_cnt/bubble_cnt  saturating counts of held-head and starved-downstream cycles
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    state_t            r_state, w_next;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [CNT_W-1:0]  r_stall, r_bubble;
    logic              w_accept, w_pop, w_load_main, w_load_skid, w_skid_to_main;
    generate
        if (SKID != 0 && SKID != 1) begin : g_bad_skid
            $error("pipe_stage_reg: SKID must be 0 or 1");
        end
    endgenerate
    assign out_valid  = r_state != EMPTY;
    // SKID=1 decodes ready straight from state flops, so no path from out_ready
    assign in_ready   = (SKID == 1) ? (r_state != TWO) : (!out_valid || out_ready);
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall;
    assign bubble_cnt = r_bubble;
    assign w_accept   = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next      = ONE;
                        w_load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_next      = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_next         = ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_skid_to_main) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall  <= '0;
            r_bubble <= '0;
        end else begin
            r_stall  <= (out_valid && !out_ready && r_stall != '1) ? r_stall + CNT_ONE : r_stall;
            r_bubble <= (!out_valid && out_ready && r_bubble != '1) ? r_bubble + CNT_ONE : r_bubble;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg (SKID=1, SKID=0 and CNT_W=4 instances)
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [8:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic        rdy1, ov1, rdy0, ov0, rdy4, ov4;
    logic [8:0]  oc1, oc0, oc4;
    logic [95:0] od1, od0, od4;
    logic [15:0] sc1, bc1, sc0, bc0;
    logic [3:0]  sc4, bc4;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(9), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1), .bubble_cnt(bc1));
    pipe_stage_reg #(.DATA_W(96), .CTRL_W(9), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0), .bubble_cnt(bc0));
    pipe_stage_reg #(.DATA_W(96), .CTRL_W(9), .SKID(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_ctrl(oc4), .out_data(od4), .stall_cnt(sc4), .bubble_cnt(bc4));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [95:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 9'h0, 96'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_valid", ov1, 1'b0);
        chk("rst_ctrl", oc1, 9'h0);
        chk("rst_data", od1, 96'h0);
        chk("rst_ready", rdy1, 1'b1);
        chk("rst_stall", sc1, 16'h0);
        chk("rst_bubble", bc1, 16'h0);

        // latency and streaming
        out_ready = 1'b1;
        drive(1'b1, 9'h1A5, 96'hA);
        tick();
        chk("lat_valid", ov1, 1'b1);
        chk("lat_ctrl", oc1, 9'h1A5);
        chk("lat_data", od1, 96'hA);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 9'(i + 16), 96'(32'hC0DE_0000 + i));
            tick();
            chk("stream_valid", ov1, 1'b1);
            chk("stream_ctrl", oc1, 9'(i + 16));
            chk("stream_data", od1, 96'(32'hC0DE_0000 + i));
        end
        drive(1'b0, 9'h0, 96'h0);
        tick();
        chk("drain_valid", ov1, 1'b0);
        chk("drain_ctrl", oc1, 9'h0);
        chk("drain_data_kept", od1, 96'hC0DE_0007);

        // backpressure fills the skid entry
        do_reset();
        drive(1'b1, 9'h011, 96'hAAAA);
        tick();
        chk("bp_x_valid", ov1, 1'b1);
        chk("bp_x_ready", rdy1, 1'b1);
        drive(1'b1, 9'h022, 96'hBBBB);
        tick();
        chk("bp_full_ready", rdy1, 1'b0);
        chk("bp_head_x", od1, 96'hAAAA);
        drive(1'b0, 9'h0, 96'h0);
        tick();
        tick();
        chk("bp_stall3", sc1, 16'd3);
        out_ready = 1'b1;
        tick();
        chk("bp_y_data", od1, 96'hBBBB);
        chk("bp_y_ctrl", oc1, 9'h022);
        chk("bp_y_ready", rdy1, 1'b1);
        chk("bp_stall_hold", sc1, 16'd3);
        tick();
        chk("bp_empty", ov1, 1'b0);
        chk("bp_bubble0", bc1, 16'd0);

        // flush while full with input offered
        do_reset();
        drive(1'b1, 9'h011, 96'h1111);
        tick();
        drive(1'b1, 9'h022, 96'h2222);
        tick();
        drive(1'b1, 9'h033, 96'h3333);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 9'h0, 96'h0);
        chk("fl_valid", ov1, 1'b0);
        chk("fl_ctrl", oc1, 9'h0);
        chk("fl_ready", rdy1, 1'b1);
        chk("fl_stall_kept", sc1, 16'd2);
        out_ready = 1'b1;
        tick();
        chk("fl_no_item", ov1, 1'b0);
        drive(1'b1, 9'h044, 96'h4444);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 9'h0, 96'h0);
        chk("fl_drop_ready_item", ov1, 1'b0);
        chk("fl_data_kept", od1, 96'h1111);

        // asynchronous reset while full
        do_reset();
        drive(1'b1, 9'h055, 96'h5555);
        tick();
        drive(1'b1, 9'h066, 96'h6666);
        tick();
        drive(1'b0, 9'h0, 96'h0);
        tick();
        chk("ar_pre_ready", rdy1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", ov1, 1'b0);
        chk("ar_ctrl", oc1, 9'h0);
        chk("ar_data", od1, 96'h0);
        chk("ar_ready", rdy1, 1'b1);
        chk("ar_stall", sc1, 16'h0);
        tick();
        rst_n = 1'b1;

        // single-entry variant
        do_reset();
        drive(1'b1, 9'h077, 96'h7777);
        tick();
        drive(1'b0, 9'h0, 96'h0);
        chk("s0_valid", ov0, 1'b1);
        chk("s0_ready_low", rdy0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("s0_ready_comb", rdy0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9'(i + 9'h100), 96'(i + 32'hD000));
            tick();
            chk("s0_stream_data", od0, 96'(i + 32'hD000));
            chk("s0_stream_ctrl", oc0, 9'(i + 9'h100));
        end
        drive(1'b0, 9'h0, 96'h0);
        tick();
        chk("s0_empty", ov0, 1'b0);

        // bubble counter saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", bc4, 4'd14);
        tick();
        chk("sat_15", bc4, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", bc4, 4'd15);
        chk("sat_stall0", sc4, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
